// File: rtl/rpc2_ctrl_wr_pkg.sv
// rpc2_ctrl_wr_pkg: write-address entry layout, burst encodings and IP-word length arithmetic
package rpc2_ctrl_wr_pkg;
  localparam int ENTRY_W = 45;
  localparam int ADDR_LSB = 0;
  localparam int LEN_LSB = 32;
  localparam int BURST_LSB = 40;
  localparam int SIZE_LSB = 42;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  typedef struct packed {
    logic [2:0] size;
    logic [1:0] burst;
    logic [7:0] len;
    logic [31:0] addr;
  } aw_entry_t;
  function automatic logic [11:0] lm(input logic [3:0] k);
    return 12'((13'd1 << k) - 13'd1);
  endfunction
  // Result is IP beats - 1; computed in 12 bits and masked to the 8+ab bit length field.
  function automatic logic [11:0] ip_len_calc(input logic [2:0] size, input logic [1:0] burst,
                                              input logic [7:0] len, input logic [3:0] addr_lsb,
                                              input logic [2:0] ip_size, input logic [2:0] ab);
    logic [2:0] s;
    logic [11:0] msk, blen, a, r;
    s = (size > ab) ? ab : size;
    msk = lm(4'(ab) + 4'd8);
    blen = ((({4'd0, len} + 12'd1) << s) - 12'd1) & msk;
    a = {8'd0, addr_lsb} & lm({1'b0, ab});
    r = (ip_size == s) ? blen :
        (ip_size > s) ? ((blen + (a & ~lm({1'b0, s}) & lm({1'b0, ip_size}))) & msk) :
        ((blen - (a & lm({1'b0, s}))) & msk);
    return (ip_size > s && burst == BURST_FIXED) ? {4'd0, len} : (r >> ip_size);
  endfunction
endpackage

// File: rtl/rpc2_ctrl_rr_arbiter.sv
// rpc2_ctrl_rr_arbiter: round-robin grant starting one past the last granted requester
module rpc2_ctrl_rr_arbiter #(
  parameter int N = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);
  logic [IW-1:0] last_q, last_d;
  int idx;
  // first requester found scanning from last_q+1 wraps around to last_q
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (en && !gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    last_d = gnt_vld ? gnt_idx : last_q;
  end
  // reset to N-1 so block 0 is considered first
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_q <= IW'(N - 1);
    else last_q <= last_d;
endmodule

// File: rtl/rpc2_ctrl_axi_wr_addr_arb_n.sv
// rpc2_ctrl_axi_wr_addr_arb_n: credit-gated round-robin write-address arbiter with IP length calc; RPC2_CTRL_WR_NOWAIT_EN bypasses credits
module rpc2_ctrl_axi_wr_addr_arb_n
  import rpc2_ctrl_wr_pkg::*;
#(
  parameter int NUM_BLK = 2,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int CREDIT_W = 4,
  localparam int AB = $clog2(C_AXI_DATA_WIDTH / 8),
  localparam int IP_LEN = 8 + AB,
  localparam int BLK_W = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1,
  localparam int DIN_W = 37 + IP_LEN
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_BLK-1:0]         aw_valid,
  input  logic [NUM_BLK*ENTRY_W-1:0] aw_entry,
  output logic [NUM_BLK-1:0]         aw_ready,
  input  logic [NUM_BLK-1:0]         wdata_start,
  input  logic [2:0]                 ip_data_size,
  output logic                       adr_aw_valid,
  input  logic                       adr_aw_ready,
  output logic [DIN_W-1:0]           adr_aw_din,
  output logic [BLK_W-1:0]           adr_aw_block,
  output logic                       credit_ovf
);
  logic [NUM_BLK-1:0] elig, gnt;
  logic [BLK_W-1:0] gnt_idx;
  logic gnt_vld, adv, s2_adv, s2_load;
  aw_entry_t gnt_ent, s1_ent_q, s1_ent_d;
  logic s1_vld_q, s1_vld_d, adr_aw_valid_q, adr_aw_valid_d;
  logic [BLK_W-1:0] s1_blk_q, s1_blk_d, adr_aw_block_q, adr_aw_block_d;
  logic [DIN_W-1:0] adr_aw_din_q, adr_aw_din_d;
  logic [IP_LEN-1:0] ip_len;
  assign s2_adv = ~adr_aw_valid_q | adr_aw_ready;
  assign adv = reset_n & (~s1_vld_q | s2_adv);
  assign gnt_ent = aw_entry_t'(aw_entry[int'(gnt_idx)*ENTRY_W +: ENTRY_W]);
  assign aw_ready = gnt;
  assign adr_aw_valid = adr_aw_valid_q;
  assign adr_aw_din = adr_aw_din_q;
  assign adr_aw_block = adr_aw_block_q;
  assign ip_len = IP_LEN'(ip_len_calc(s1_ent_q.size, s1_ent_q.burst, s1_ent_q.len,
                                      s1_ent_q.addr[3:0], ip_data_size, 3'(AB)));
  rpc2_ctrl_rr_arbiter #(.N(NUM_BLK), .IW(BLK_W)) u_arb (
    .clk(clk), .reset_n(reset_n), .req(elig), .en(adv),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld)
  );
`ifdef RPC2_CTRL_WR_NOWAIT_EN
  logic unused_wdata;
  assign unused_wdata = ^wdata_start;
  assign elig = aw_valid;
  assign credit_ovf = 1'b0;
`else
  logic [CREDIT_W-1:0] credit_q [NUM_BLK];
  logic [CREDIT_W-1:0] credit_d [NUM_BLK];
  logic [NUM_BLK-1:0] cred_nz;
  logic ovf_q, ovf_d;
  assign elig = aw_valid & cred_nz;
  assign credit_ovf = ovf_q;
  // +1 per accepted data burst, -1 per grant, saturating with sticky overflow flag
  always_comb begin
    ovf_d = ovf_q;
    cred_nz = '0;
    for (int i = 0; i < NUM_BLK; i++) begin
      credit_d[i] = (wdata_start[i] & ~gnt[i]) ? ((&credit_q[i]) ? credit_q[i] : credit_q[i] + CREDIT_W'(1)) :
                    (~wdata_start[i] & gnt[i]) ? credit_q[i] - CREDIT_W'(1) : credit_q[i];
      ovf_d = ovf_d | (wdata_start[i] & ~gnt[i] & (&credit_q[i]));
      cred_nz[i] = |credit_q[i];
    end
  end
  // credit counters and overflow flag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ovf_q <= 1'b0;
      for (int i = 0; i < NUM_BLK; i++) credit_q[i] <= '0;
    end else begin
      ovf_q <= ovf_d;
      for (int i = 0; i < NUM_BLK; i++) credit_q[i] <= credit_d[i];
    end
`endif
  // S1 holds the granted entry; S2 holds the computed output and drains on ready
  always_comb begin
    s2_load = s1_vld_q & s2_adv;
    s1_vld_d = gnt_vld | (s1_vld_q & ~s2_adv);
    s1_ent_d = gnt_vld ? gnt_ent : s1_ent_q;
    s1_blk_d = gnt_vld ? gnt_idx : s1_blk_q;
    adr_aw_valid_d = s2_load | (adr_aw_valid_q & ~adr_aw_ready);
    adr_aw_din_d = s2_load ? {s1_ent_q.size, s1_ent_q.burst, ip_len, s1_ent_q.addr} : adr_aw_din_q;
    adr_aw_block_d = s2_load ? s1_blk_q : adr_aw_block_q;
  end
  // pipeline registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_vld_q <= 1'b0;
      s1_ent_q <= '0;
      s1_blk_q <= '0;
      adr_aw_valid_q <= 1'b0;
      adr_aw_din_q <= '0;
      adr_aw_block_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_ent_q <= s1_ent_d;
      s1_blk_q <= s1_blk_d;
      adr_aw_valid_q <= adr_aw_valid_d;
      adr_aw_din_q <= adr_aw_din_d;
      adr_aw_block_q <= adr_aw_block_d;
    end
endmodule

// File: tb/tb_rpc2_ctrl_axi_wr_addr_arb_n.sv
// tb_rpc2_ctrl_axi_wr_addr_arb_n: directed checks of grant order, credits, length math and backpressure
module tb_rpc2_ctrl_axi_wr_addr_arb_n;
  import rpc2_ctrl_wr_pkg::*;
`ifdef RPC2_CTRL_WR_NOWAIT_EN
  localparam bit NW = 1'b1;
`else
  localparam bit NW = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  logic [1:0] v0 = '0, r0, ws0 = '0;
  logic [89:0] e0 = '0;
  logic [2:0] ip0 = 3'd2;
  logic ov0, or0 = 1'b1, blk0, ovf0;
  logic [46:0] d0;
  logic [3:0] v1 = '0, r1, ws1 = '0, pop;
  logic [179:0] e1 = '0;
  logic [2:0] ip1 = 3'd3;
  logic ov1, or1 = 1'b1, ovf1;
  logic [47:0] d1;
  logic [1:0] b1;
  logic [1:0] v2 = '0, r2, ws2 = '0;
  logic [89:0] e2 = '0;
  logic [2:0] ip2 = 3'd1;
  logic ov2, or2 = 1'b1, b2, ovf2;
  logic [48:0] d2;
  logic [3:0] exp_r [7] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd0, 4'd0};
  logic [1:0] exp_b [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] exp_re [9] = '{4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
  logic exp_ov [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] exp_be [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
  rpc2_ctrl_axi_wr_addr_arb_n #(.NUM_BLK(2), .C_AXI_DATA_WIDTH(32), .CREDIT_W(4)) u0 (
    .clk(clk), .reset_n(reset_n), .aw_valid(v0), .aw_entry(e0), .aw_ready(r0),
    .wdata_start(ws0), .ip_data_size(ip0), .adr_aw_valid(ov0), .adr_aw_ready(or0),
    .adr_aw_din(d0), .adr_aw_block(blk0), .credit_ovf(ovf0));
  rpc2_ctrl_axi_wr_addr_arb_n #(.NUM_BLK(4), .C_AXI_DATA_WIDTH(64), .CREDIT_W(4)) u1 (
    .clk(clk), .reset_n(reset_n), .aw_valid(v1), .aw_entry(e1), .aw_ready(r1),
    .wdata_start(ws1), .ip_data_size(ip1), .adr_aw_valid(ov1), .adr_aw_ready(or1),
    .adr_aw_din(d1), .adr_aw_block(b1), .credit_ovf(ovf1));
  rpc2_ctrl_axi_wr_addr_arb_n #(.NUM_BLK(2), .C_AXI_DATA_WIDTH(128), .CREDIT_W(4)) u2 (
    .clk(clk), .reset_n(reset_n), .aw_valid(v2), .aw_entry(e2), .aw_ready(r2),
    .wdata_start(ws2), .ip_data_size(ip2), .adr_aw_valid(ov2), .adr_aw_ready(or2),
    .adr_aw_din(d2), .adr_aw_block(b2), .credit_ovf(ovf2));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [44:0] ent(input logic [2:0] s, input logic [1:0] b, input logic [7:0] l, input logic [31:0] a);
    return {s, b, l, a};
  endfunction
  initial begin
    v0 = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    check("rst_aw_ready", 64'(r0), 64'd0);
    check("rst_valid", 64'(ov0), 64'd0);
    check("rst_din", 64'(d1), 64'd0);
    check("rst_blk", 64'(b1), 64'd0);
    check("rst_ovf", 64'({ovf0, ovf1, ovf2}), 64'd0);
    v0 = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    e0 = {ent(3'd2, BURST_INCR, 8'd3, 32'h100), ent(3'd2, BURST_INCR, 8'd0, 32'h200)};
    ws0 = 2'b10;
`ifndef RPC2_CTRL_WR_NOWAIT_EN
    v0 = 2'b10;
    #1 check("a_same_cycle_credit", 64'(r0), 64'd0);
`endif
    @(negedge clk);
    ws0 = 2'b00;
    v0 = NW ? 2'b10 : 2'b11;
    #1 check("a_grant", 64'(r0), 64'd2);
    @(negedge clk);
    v0 = 2'b00;
    #1 check("a_t1_valid", 64'(ov0), 64'd0);
    check("a_no_regrant", 64'(r0), 64'd0);
    @(negedge clk);
    check("a_t2_valid", 64'(ov0), 64'd1);
    check("a_blk", 64'(blk0), 64'd1);
    check("a_din", 64'(d0), 64'({3'd2, 2'b01, 10'd3, 32'h100}));
    @(negedge clk);
    check("a_drain", 64'(ov0), 64'd0);
    ws1 = 4'hF;
    @(negedge clk);
    ws1 = 4'h1;
    @(negedge clk);
    ws1 = 4'h0;
    for (int i = 0; i < 4; i++) e1[i*45 +: 45] = ent(3'd3, BURST_INCR, 8'd1, 32'h1000 + 32'(i * 16));
    v1 = 4'hF;
    for (int k = 0; k < 7; k++) begin
      #1 check("b_rr_grant", 64'(r1), 64'(exp_r[k]));
      check("b_valid", 64'(ov1), (k >= 2) ? 64'd1 : 64'd0);
      if (k >= 2) check("b_blk", 64'(b1), 64'(exp_b[k-2]));
      if (k == 2) check("b_din", 64'(d1), 64'({3'd3, 2'b01, 11'd1, 32'h1000}));
      @(negedge clk);
      if (k == 4) v1 = 4'h0;
    end
    check("b_drain", 64'(ov1), 64'd0);
    ws1 = 4'h1;
    @(negedge clk);
    @(negedge clk);
    ws1 = 4'h0;
    e1[0 +: 45] = ent(3'd1, BURST_INCR, 8'd7, 32'h6);
    v1 = 4'h1;
    #1 check("c_grant_incr", 64'(r1), 64'd1);
    @(negedge clk);
    e1[0 +: 45] = ent(3'd1, BURST_FIXED, 8'd7, 32'h6);
    #1 check("c_grant_fixed", 64'(r1), 64'd1);
    @(negedge clk);
    v1 = 4'h0;
    check("c_len_incr64", 64'(d1), 64'({3'd1, 2'b01, 11'd2, 32'h6}));
    @(negedge clk);
    check("c_len_fixed64", 64'(d1), 64'({3'd1, 2'b00, 11'd7, 32'h6}));
    ws2 = 2'b01;
    @(negedge clk);
    ws2 = 2'b00;
    e2[0 +: 45] = ent(3'd4, BURST_INCR, 8'd3, 32'h4);
    v2 = 2'b01;
    #1 check("d_grant", 64'(r2), 64'd1);
    @(negedge clk);
    v2 = 2'b00;
    @(negedge clk);
    check("d_valid", 64'(ov2), 64'd1);
    check("d_len_128", 64'(d2), 64'({3'd4, 2'b01, 12'd29, 32'h4}));
    check("d_blk", 64'(b2), 64'd0);
    or1 = 1'b0;
    ws1 = 4'b0111;
    @(negedge clk);
    ws1 = 4'h0;
    for (int i = 0; i < 3; i++) e1[i*45 +: 45] = ent(3'd3, BURST_INCR, 8'd1, 32'h2000 + 32'(i * 16));
    v1 = 4'b0111;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) or1 = 1'b1;
      #1 check("e_aw_ready", 64'(r1), 64'(exp_re[k]));
      check("e_valid", 64'(ov1), 64'(exp_ov[k]));
      if (exp_ov[k]) check("e_blk", 64'(b1), 64'(exp_be[k]));
      if (k >= 2 && k <= 4) check("e_din_held", 64'(d1), 64'({3'd3, 2'b01, 11'd1, 32'h2010}));
      pop = r1;
      @(negedge clk);
      v1 = v1 & ~pop;
    end
    ws0 = 2'b01;
    repeat (15) @(negedge clk);
    ws0 = 2'b00;
    #1 check("f_no_ovf_at_15", 64'(ovf0), 64'd0);
    @(negedge clk);
    ws0 = 2'b01;
    @(negedge clk);
    ws0 = 2'b00;
    #1 check("f_ovf_sticky", 64'(ovf0), NW ? 64'd0 : 64'd1);
    v0 = 2'b01;
    #1 check("f_grant_blk0", 64'(r0), 64'd1);
    @(negedge clk);
    v0 = 2'b00;
    reset_n = 1'b0;
    #1 check("g_rst_valid", 64'(ov0), 64'd0);
    check("g_rst_ovf", 64'(ovf0), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("g_inflight_dropped", 64'(ov0), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
